shift_add_mul: RTL and testbench
================================

// Module: shift_add_mul
// PURPOSE
//   Sequential unsigned multiplier that sits directly upstream of, and drives, a ripple-carry adder stage.
//   It is a shift-and-add controller: it reuses one WIDTH-bit ripple-carry adder once per multiplier bit.
//   Operands come from switch/DIP inputs. The product goes to the LED/display stage.
// PARAMETERS
//   WIDTH   4   operand width in bits; product is 2*WIDTH bits
// PORTS
//   clk      in   1          single clock, rising edge
//   rst_n    in   1          synchronous reset, active-low (sampled on clk rising edge only)
//   start    in   1          request: latch a/b and begin; sampled only in IDLE
//   a        in   WIDTH      multiplicand
//   b        in   WIDTH      multiplier
//   busy     out  1          high while state==RUN
//   done     out  1          one-cycle pulse when product becomes valid
//   product  out  2*WIDTH    a*b; held stable from done until the next accepted start
// BEHAVIOUR
//   - Reset (rst_n==0 at an edge): state=IDLE, busy=0, done=0, product=0, internal regs=0.
//     Reset applies in any state, including mid-RUN; the partial result is discarded.
//   - FSM states:
//     IDLE --start--> RUN
//     RUN --cnt==WIDTH-1--> DONE
//     DONE --> IDLE (unconditional)
//   - Start acceptance: start accepted at edge k (state IDLE) latches M<=a, Q<=b, A<=0, cnt<=0.
//   - RUN step, one per cycle, WIDTH cycles:
//     sum/carry = A + (Q[0] ? M : 0) via the adder
//     {A,Q} <= {carry,sum,Q} >> 1
//     cnt++
//   - Latency: busy=1 during cycles k+1..k+WIDTH. done=1 in cycle k+WIDTH+1 only.
//     product={A,Q} is registered on entry to DONE.
//   - Start while RUN or DONE: ignored, with no effect on operands or count. A caller wanting
//     back-to-back operation re-asserts start in the cycle after done.
//   - Width rules: A is WIDTH bits and the adder carry-out is the shifted-in MSB, so no overflow
//     is possible. Max product is (2^WIDTH-1)^2, e.g. 0xE1 for WIDTH=4.
//   - a/b may change freely after acceptance; only latched copies are used.
//   - done and busy are never high together.
// CONFIGURATION
//   ZERO_SKIP_EN defined: if a==0 or b==0 when start is accepted, the FSM goes IDLE->DONE directly.
//     busy stays 0, done pulses at k+1, product=0.
//   ZERO_SKIP_EN undefined: zero operands take the full WIDTH RUN cycles like any other operands.
// STRUCTURE
//   - Package mul_pkg:
//     state enum {IDLE, RUN, DONE}
//     WIDTH_DEFAULT=4
//     cnt width = $clog2(WIDTH)
//   - One sub-module, rca_adder #(WIDTH), instantiated once:
//     combinational ripple-carry adder built from per-bit full adders
//     ports: a, b, c_in (tied 0), s, c_out
//   - The controller holds the FSM, the cnt counter and the M/A/Q registers.
// TESTING
//   1. a=15, b=15, start 1 cycle -> busy for 4 cycles, done pulse at k+5, product=0xE1; held until next start.
//   2. a=1, b=1 -> product=0x01. a=0xA, b=0x3 -> product=0x1E. Exhaustive 256-pair sweep matches a*b.
//   3. start held high through RUN with a/b changed mid-operation -> result uses the first operands;
//      no second operation until IDLE.
//   4. rst_n=0 for 1 cycle at RUN cycle 2 -> next cycle state=IDLE, busy=0, done=0, product=0;
//      a new start then completes correctly.
//   5. a=0, b=9 -> ZERO_SKIP_EN defined: done at k+1, busy never high, product=0.
//      ZERO_SKIP_EN undefined: done at k+5, product=0.
//   6. start asserted in the DONE cycle -> ignored; start in the following cycle accepted normally.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
package mul_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width; kept at least one bit so WIDTH=1 still elaborates.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/rca_adder.sv
// Purpose: combinational WIDTH-bit ripple-carry adder built from per-bit full adders.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows inputs.
module rca_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    logic [WIDTH:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[WIDTH];

endmodule

// File: rtl/shift_add_mul.sv
// Purpose: sequential unsigned shift-and-add multiplier reusing one ripple-carry adder (ZERO_SKIP_EN: zero operands skip RUN).
// Latency: start accepted at edge k, busy k+1..k+WIDTH, done pulse at k+WIDTH+1 (k+1 with zero skip).
// Backpressure: start is sampled only in IDLE; requests during RUN/DONE are dropped, caller re-asserts.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic               skip;

    assign addend = q_reg[0] ? m_reg : '0;

    rca_adder #(.WIDTH(WIDTH)) u_rca_adder (
        .a     (a_reg),
        .b     (addend),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (carry)
    );

`ifdef ZERO_SKIP_EN
    assign skip = (a == '0) || (b == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            m_reg   <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= a;
                        q_reg <= b;
                        a_reg <= '0;
                        cnt   <= '0;
                        if (skip) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            product <= '0;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Carry-out becomes the new MSB of A, so the partial product never overflows.
                    a_reg <= {carry, sum[WIDTH-1:1]};
                    q_reg <= {sum[0], q_reg[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= {carry, sum, q_reg[WIDTH-1:1]};
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mul.sv
// Bench for shift_add_mul: per-cycle comparison against a countdown/arithmetic model plus literal spot checks.
module tb_shift_add_mul;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_cmp = 0;
    int n_err = 0;

    shift_add_mul #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

`ifdef ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining RUN cycles, a done flag, and the arithmetic product of accepted operands.
    int         m_left = 0;
    bit         m_busy = 0;
    bit         m_done = 0;
    int         m_prod = 0;
    int         m_pend = 0;
    bit         m_cmp_en = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0; m_busy = 0; m_done = 0; m_prod = 0;
            m_cmp_en = 1;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1; m_prod = m_pend;
            end
        end else if (start) begin
            if (ZSKIP && (a == 0 || b == 0)) begin
                m_done = 1; m_prod = 0;
            end else begin
                m_busy = 1; m_left = W; m_pend = int'(a) * int'(b);
            end
        end
        #1;
        if (m_cmp_en) begin
            check("busy", int'(busy), int'(m_busy));
            check("done", int'(done), int'(m_done));
            check("product", int'(product), m_prod);
            check("busy_and_done_exclusive", int'(busy & done), 0);
        end
    end

    int lat;
    int got;

    // Pulse start for one cycle, then wait (bounded) for done; lat counts negedges from the drive.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; a = x; b = y;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
            lat++;
        end while (!done && lat < 20);
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: no done within %0d cycles for a=%0d b=%0d", lat, x, y);
        end
        got = int'(product);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_product", int'(product), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Max operands: four busy cycles, done five cycles after the drive.
        run_op(4'hF, 4'hF);
        check("max_latency", lat, W + 1);
        check("max_product", got, 8'hE1);
        repeat (3) begin
            @(negedge clk);
            check("product_held", int'(product), 8'hE1);
        end

        run_op(4'h1, 4'h1);
        check("one_by_one", got, 8'h01);
        @(negedge clk);
        run_op(4'hA, 4'h3);
        check("a_by_3", got, 8'h1E);
        @(negedge clk);

        // Start held through RUN with operands changing: first operands win.
        start = 1'b1; a = 4'd5; b = 4'd7;
        @(negedge clk); a = 4'd9; b = 4'd9;
        @(negedge clk); a = 4'd2; b = 4'd3;
        @(negedge clk); start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        check("held_start_product", int'(product), 35);
        @(negedge clk);
        check("held_start_no_rerun", int'(busy), 0);

        // Reset pulse in the second RUN cycle discards the operation.
        start = 1'b1; a = 4'd13; b = 4'd11;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("midrun_reset_busy", int'(busy), 0);
        check("midrun_reset_done", int'(done), 0);
        check("midrun_reset_product", int'(product), 0);
        @(negedge clk);
        run_op(4'd6, 4'd7);
        check("after_reset_product", got, 42);
        @(negedge clk);

        run_op(4'd0, 4'd9);
        check("zero_latency", lat, ZSKIP ? 1 : W + 1);
        check("zero_product", got, 0);

        // We are in the DONE cycle: this start is ignored, the next cycle's start is taken.
        start = 1'b1; a = 4'd3; b = 4'd3;
        @(negedge clk);
        a = 4'd2; b = 4'd5;
        run_op(4'd2, 4'd5);
        check("post_done_latency", lat, W + 1);
        check("post_done_product", got, 10);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(W'(i), W'(j));
                check("sweep", got, i * j);
                @(negedge clk);
            end
        end

        // Random traffic with stray start pulses; the per-cycle model does the checking.
        for (int n = 0; n < 300; n++) begin
            start = 1'($urandom_range(0, 2) == 0);
            a = W'($urandom);
            b = W'($urandom_range(0, 5) == 0 ? 0 : $urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
